// File: rtl/kwl_pkg.sv
// Shared definitions for the kernel weight loader:
// config register map, CTRL bit positions and FSM states.
package kwl_pkg;

    localparam logic [4:0] REG_CTRL   = 5'd0;
    localparam logic [4:0] REG_KWORDS = 5'd1;
    localparam logic [4:0] REG_IMG_W  = 5'd2;
    localparam logic [4:0] REG_IMG_H  = 5'd3;
    localparam logic [4:0] REG_NUM_CH = 5'd4;

    localparam int CTRL_START = 0;
    localparam int CTRL_ARM   = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/kwl_cfg_regs.sv
// Config register file fed by the Xillybus config stream.
// Decodes START/ARM strobes and rejects oversized NUM_CH.
module kwl_cfg_regs #(
    parameter int ADDR_W = 12,
    parameter int MAX_CH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wren,
    input  logic [4:0]        cfg_addr,
    input  logic [31:0]       cfg_data,
    input  logic              busy,
    output logic [ADDR_W:0]   kwords,
    output logic [15:0]       img_width,
    output logic [15:0]       img_height,
    output logic [7:0]        num_ch,
    output logic              start_req,
    output logic              arm_req,
    output logic              num_ch_err
);
    import kwl_pkg::*;

    logic ctrl_wr;
    logic num_ch_wr;

    assign ctrl_wr    = cfg_wren && (cfg_addr == REG_CTRL);
    assign num_ch_wr  = cfg_wren && (cfg_addr == REG_NUM_CH);
    assign start_req  = ctrl_wr && cfg_data[CTRL_START];
    assign arm_req    = ctrl_wr && cfg_data[CTRL_ARM];
    assign num_ch_err = num_ch_wr && (cfg_data > 32'(MAX_CH));

    // Register writes; KWORDS is frozen during a load,
    // an illegal NUM_CH leaves the old value in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kwords     <= '0;
            img_width  <= '0;
            img_height <= '0;
            num_ch     <= '0;
        end else if (cfg_wren) begin
            case (cfg_addr)
                REG_KWORDS: if (!busy) kwords <= cfg_data[ADDR_W:0];
                REG_IMG_W:  img_width  <= cfg_data[15:0];
                REG_IMG_H:  img_height <= cfg_data[15:0];
                REG_NUM_CH: if (!num_ch_err) num_ch <= cfg_data[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/kernel_weight_loader.sv
// Drains the kernel FIFO into the weight RAM under a
// programmed word count and hands off to the conv pipeline.
module kernel_weight_loader #(
    parameter int ADDR_W = 12,
    parameter int MAX_CH = 64
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              cfg_wren,
    input  logic [4:0]        cfg_addr,
    input  logic [31:0]       cfg_data,
    output logic              cfg_full,
    input  logic              kernel_open,
    input  logic [31:0]       kfifo_dout,
    input  logic              kfifo_empty,
    output logic              kfifo_rd_en,
    output logic              wmem_we,
    output logic [ADDR_W-1:0] wmem_addr,
    output logic [31:0]       wmem_wdata,
    output logic [15:0]       img_width,
    output logic [15:0]       img_height,
    output logic [7:0]        num_ch,
    output logic              weights_ready,
    output logic              load_error,
    output logic              busy,
    output logic              start
);
    import kwl_pkg::*;

    localparam logic [ADDR_W:0] KW_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nx;
    logic [ADDR_W:0] kwords;
    logic [ADDR_W:0] rd_cnt;
    logic [ADDR_W:0] wr_cnt;
    logic            start_req;
    logic            arm_req;
    logic            num_ch_err;
    logic            kw_legal;
    logic            rd_en;
    logic            rd_pend;
    logic            last_wr;
    logic            early_close;

    kwl_cfg_regs #(
        .ADDR_W (ADDR_W),
        .MAX_CH (MAX_CH)
    ) u_regs (
        .clk        (bus_clk),
        .rst_n      (bus_rst_n),
        .cfg_wren   (cfg_wren),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .busy       (busy),
        .kwords     (kwords),
        .img_width  (img_width),
        .img_height (img_height),
        .num_ch     (num_ch),
        .start_req  (start_req),
        .arm_req    (arm_req),
        .num_ch_err (num_ch_err)
    );

    assign cfg_full      = 1'b0;
    assign kw_legal      = (kwords != '0) && (kwords <= KW_MAX);
    assign busy          = (state == ST_LOAD);
    assign weights_ready = (state == ST_DONE);
    assign kfifo_rd_en   = rd_en;

    // FIFO data is valid the cycle after rd_en, so the
    // pending flag doubles as the RAM write strobe.
    assign wmem_we    = rd_pend;
    assign wmem_addr  = wr_cnt[ADDR_W-1:0];
    assign wmem_wdata = rd_pend ? kfifo_dout : '0;
    assign last_wr    = rd_pend && (wr_cnt == kwords - CNT_ONE);

    // State register.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) state <= ST_IDLE;
        else            state <= state_nx;
    end

    // Next state and read enable; ARM overrides everything.
    always_comb begin
        state_nx    = state;
        rd_en       = 1'b0;
        early_close = 1'b0;
        case (state)
            ST_LOAD: begin
                rd_en = kernel_open && !kfifo_empty
                        && (rd_cnt < kwords);
                early_close = !kernel_open && (rd_cnt < kwords);
                if (last_wr)          state_nx = ST_DONE;
                else if (early_close) state_nx = ST_ERR;
            end
            default: ;
        endcase
        if (arm_req) state_nx = kw_legal ? ST_LOAD : ST_IDLE;
    end

    // Read/write counters; ARM drops any word read this
    // cycle so a restart begins from a clean address 0.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            rd_pend <= 1'b0;
        end else if (arm_req) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en)   rd_cnt <= rd_cnt + CNT_ONE;
            if (rd_pend) wr_cnt <= wr_cnt + CNT_ONE;
        end
    end

    // Sticky error: set by bad ARM, bad NUM_CH or early
    // close; a legal ARM clears it.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            load_error <= 1'b0;
        end else if (arm_req) begin
            load_error <= !kw_legal;
        end else if (num_ch_err || (state_nx == ST_ERR)) begin
            load_error <= 1'b1;
        end
    end

    // Start pulse only from a completed load; ARM wins.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) start <= 1'b0;
        else start <= start_req && !arm_req && weights_ready;
    end

endmodule

// File: tb/tb_kernel_weight_loader.sv
// Randomized scoreboard bench for kernel_weight_loader.
// FIFO model feeds words; a monitor checks every RAM write.
module tb_kernel_weight_loader;
    import kwl_pkg::*;

    localparam int ADDR_W = 12;

    logic              bus_clk;
    logic              bus_rst_n;
    logic              cfg_wren;
    logic [4:0]        cfg_addr;
    logic [31:0]       cfg_data;
    logic              cfg_full;
    logic              kernel_open;
    logic [31:0]       kfifo_dout;
    logic              kfifo_empty;
    logic              kfifo_rd_en;
    logic              wmem_we;
    logic [ADDR_W-1:0] wmem_addr;
    logic [31:0]       wmem_wdata;
    logic [15:0]       img_width;
    logic [15:0]       img_height;
    logic [7:0]        num_ch;
    logic              weights_ready;
    logic              load_error;
    logic              busy;
    logic              start;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] fifo_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rd_count = 0;
    int          start_cnt = 0;
    int          cyc = 0;
    int          first_we = 0;
    int          last_we = 0;
    bit          seen_we = 0;
    int          gap_mode = 0;
    bit          gap = 0;

    kernel_weight_loader #(.ADDR_W(ADDR_W), .MAX_CH(64)) dut (
        .bus_clk       (bus_clk),
        .bus_rst_n     (bus_rst_n),
        .cfg_wren      (cfg_wren),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_full      (cfg_full),
        .kernel_open   (kernel_open),
        .kfifo_dout    (kfifo_dout),
        .kfifo_empty   (kfifo_empty),
        .kfifo_rd_en   (kfifo_rd_en),
        .wmem_we       (wmem_we),
        .wmem_addr     (wmem_addr),
        .wmem_wdata    (wmem_wdata),
        .img_width     (img_width),
        .img_height    (img_height),
        .num_ch        (num_ch),
        .weights_ready (weights_ready),
        .load_error    (load_error),
        .busy          (busy),
        .start         (start)
    );

    initial begin
        bus_clk = 1'b0;
        forever #5 bus_clk = ~bus_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1);
    end

    task automatic check1(input string name, input logic act,
                          input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // FIFO model: non-FWFT, data valid the cycle after rd_en.
    initial begin : fifo_model
        bit r;
        bit e;
        kfifo_dout  = '0;
        kfifo_empty = 1'b1;
        forever begin
            @(negedge bus_clk);
            r = kfifo_rd_en;
            e = kfifo_empty;
            if (r) check1("rd_when_empty", e, 1'b0);
            @(posedge bus_clk);
            #1;
            if (r) begin
                rd_count++;
                if (fifo_q.size() > 0) kfifo_dout = fifo_q.pop_front();
            end
            gap = !gap;
            kfifo_empty = (fifo_q.size() == 0)
                || (gap_mode == 1 && gap)
                || (gap_mode == 2 && $urandom_range(0, 2) == 0);
        end
    end

    // Monitor: every RAM write is popped against the scoreboard.
    initial begin : monitor
        bit  prev_rd;
        wr_t w;
        prev_rd = 1'b0;
        forever begin
            @(negedge bus_clk);
            cyc++;
            if (start) start_cnt++;
            if (wmem_we) begin
                check1("write_latency", prev_rd, 1'b1);
                if (!seen_we) first_we = cyc;
                seen_we = 1'b1;
                last_we = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                             wmem_addr, wmem_wdata);
                end else begin
                    w = exp_q.pop_front();
                    check32("wr_addr", 32'(wmem_addr), 32'(w.a));
                    check32("wr_data", wmem_wdata, w.d);
                end
            end
            prev_rd = kfifo_rd_en;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge bus_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        cfg_wren = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge bus_clk);
        #1;
        cfg_wren = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
    endtask

    // Reference: word i of the stream lands at address i,
    // for the first k words only.
    task automatic queue_load(input int k, input int n, input bit rnd,
                              input logic [31:0] base);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? 32'($urandom) : base + 32'(i);
            fifo_q.push_back(w);
            if (i < k) exp_q.push_back('{a: ADDR_W'(i), d: w});
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            tick(1);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
        tick(1);
    endtask

    task automatic wait_reads(input string name, input int target);
        int n;
        n = 0;
        while (rd_count < target && n < 200) begin
            @(posedge bus_clk);
            #2;
            n++;
        end
        if (rd_count < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d required=%0d",
                     name, rd_count, target);
        end
    endtask

    initial begin : stim
        int rd0;
        int s0;
        int k;
        int n;
        bus_rst_n   = 1'b0;
        cfg_wren    = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        kernel_open = 1'b1;
        #3;
        check1("rst_busy", busy, 1'b0);
        check1("rst_rd_en", kfifo_rd_en, 1'b0);
        check1("rst_we", wmem_we, 1'b0);
        check32("rst_addr", 32'(wmem_addr), 32'd0);
        check32("rst_wdata", wmem_wdata, 32'd0);
        check1("rst_ready", weights_ready, 1'b0);
        check1("rst_err", load_error, 1'b0);
        check1("rst_start", start, 1'b0);
        check32("rst_geom", {img_width, img_height}, 32'd0);
        tick(2);
        bus_rst_n = 1'b1;
        tick(1);

        // Register readback
        cfg_write(REG_IMG_W, 32'd640);
        check32("img_width", 32'(img_width), 32'd640);
        cfg_write(REG_IMG_H, 32'd480);
        check32("img_height", 32'(img_height), 32'd480);
        cfg_write(REG_NUM_CH, 32'd3);
        check32("num_ch", 32'(num_ch), 32'd3);
        check1("cfg_full", cfg_full, 1'b0);

        // START with nothing loaded
        s0 = start_cnt;
        cfg_write(REG_CTRL, 32'd1);
        check1("start_early", start, 1'b0);
        tick(2);
        check32("start_early_cnt", 32'(start_cnt - s0), 32'd0);

        // Basic load, back-to-back
        cfg_write(REG_KWORDS, 32'd9);
        queue_load(9, 9, 1'b0, 32'h100);
        rd0 = rd_count;
        seen_we = 1'b0;
        cfg_write(REG_CTRL, 32'd2);
        check1("basic_busy", busy, 1'b1);
        wait_idle("basic", 100);
        check32("basic_reads", 32'(rd_count - rd0), 32'd9);
        check32("basic_left", 32'(exp_q.size()), 32'd0);
        check1("basic_ready", weights_ready, 1'b1);
        check1("basic_err", load_error, 1'b0);
        check32("basic_rate", 32'(last_we - first_we), 32'd8);

        // START after DONE
        s0 = start_cnt;
        cfg_write(REG_CTRL, 32'd1);
        check1("start_pulse", start, 1'b1);
        tick(1);
        check1("start_width", start, 1'b0);
        tick(2);
        check32("start_cnt", 32'(start_cnt - s0), 32'd1);

        // START and ARM together
        queue_load(9, 9, 1'b0, 32'h300);
        s0 = start_cnt;
        rd0 = rd_count;
        cfg_write(REG_CTRL, 32'd3);
        check1("sa_ready_clr", weights_ready, 1'b0);
        wait_idle("sa", 100);
        check32("sa_start_cnt", 32'(start_cnt - s0), 32'd0);
        check32("sa_reads", 32'(rd_count - rd0), 32'd9);

        // Empty gaps with a spare 10th word
        gap_mode = 1;
        queue_load(9, 10, 1'b0, 32'h200);
        rd0 = rd_count;
        cfg_write(REG_CTRL, 32'd2);
        wait_idle("gap", 100);
        tick(4);
        check32("gap_reads", 32'(rd_count - rd0), 32'd9);
        check32("gap_spare", 32'(fifo_q.size()), 32'd1);
        check32("gap_left", 32'(exp_q.size()), 32'd0);
        check1("gap_ready", weights_ready, 1'b1);
        gap_mode = 0;
        fifo_q.delete();

        // Early close after 5 reads
        cfg_write(REG_KWORDS, 32'd16);
        queue_load(5, 16, 1'b1, 32'd0);
        rd0 = rd_count;
        cfg_write(REG_CTRL, 32'd2);
        wait_reads("close", rd0 + 5);
        kernel_open = 1'b0;
        tick(3);
        check32("close_reads", 32'(rd_count - rd0), 32'd5);
        check32("close_left", 32'(exp_q.size()), 32'd0);
        check1("close_err", load_error, 1'b1);
        check1("close_ready", weights_ready, 1'b0);
        check1("close_busy", busy, 1'b0);
        fifo_q.delete();
        kernel_open = 1'b1;
        tick(1);
        cfg_write(REG_CTRL, 32'd2);
        check1("rearm_err_clr", load_error, 1'b0);
        check1("rearm_busy", busy, 1'b1);
        cfg_write(REG_KWORDS, 32'd3);
        rd0 = rd_count;
        queue_load(16, 16, 1'b1, 32'd0);
        wait_idle("rearm", 200);
        check32("kw_frozen_reads", 32'(rd_count - rd0), 32'd16);
        check32("rearm_left", 32'(exp_q.size()), 32'd0);

        // NUM_CH legality
        cfg_write(REG_NUM_CH, 32'd65);
        check1("nch_err", load_error, 1'b1);
        check32("nch_keep", 32'(num_ch), 32'd3);
        cfg_write(REG_NUM_CH, 32'd64);
        check32("nch_max", 32'(num_ch), 32'd64);

        // KWORDS = 0
        cfg_write(REG_KWORDS, 32'd1);
        queue_load(1, 1, 1'b1, 32'd0);
        cfg_write(REG_CTRL, 32'd2);
        check1("k1_err_clr", load_error, 1'b0);
        wait_idle("k1", 50);
        cfg_write(REG_KWORDS, 32'd0);
        cfg_write(REG_CTRL, 32'd2);
        check1("k0_err", load_error, 1'b1);
        check1("k0_busy", busy, 1'b0);
        check1("k0_ready", weights_ready, 1'b0);
        fifo_q.push_back(32'hdead);
        rd0 = rd_count;
        tick(4);
        check32("k0_no_read", 32'(rd_count - rd0), 32'd0);
        fifo_q.delete();

        // KWORDS = 4097
        cfg_write(REG_KWORDS, 32'd1);
        queue_load(1, 1, 1'b1, 32'd0);
        cfg_write(REG_CTRL, 32'd2);
        wait_idle("k1b", 50);
        check1("k1b_err", load_error, 1'b0);
        cfg_write(REG_KWORDS, 32'd4097);
        cfg_write(REG_CTRL, 32'd2);
        check1("kbig_err", load_error, 1'b1);
        check1("kbig_busy", busy, 1'b0);

        // Random loads
        for (int it = 0; it < 6; it++) begin
            k = $urandom_range(1, 64);
            n = k + $urandom_range(0, 3);
            gap_mode = $urandom_range(0, 2);
            cfg_write(REG_KWORDS, 32'(k));
            queue_load(k, n, 1'b1, 32'd0);
            rd0 = rd_count;
            cfg_write(REG_CTRL, 32'd2);
            wait_idle("rand", 10 * k + 50);
            check32("rand_reads", 32'(rd_count - rd0), 32'(k));
            check32("rand_left", 32'(exp_q.size()), 32'd0);
            check1("rand_ready", weights_ready, 1'b1);
            gap_mode = 0;
            fifo_q.delete();
        end

        // Full capacity
        cfg_write(REG_KWORDS, 32'd4096);
        queue_load(4096, 4096, 1'b1, 32'd0);
        rd0 = rd_count;
        cfg_write(REG_CTRL, 32'd2);
        check1("full_err", load_error, 1'b0);
        wait_idle("full", 5000);
        check32("full_reads", 32'(rd_count - rd0), 32'd4096);
        check32("full_left", 32'(exp_q.size()), 32'd0);
        check1("full_ready", weights_ready, 1'b1);

        // ARM restart mid-LOAD
        cfg_write(REG_KWORDS, 32'd8);
        queue_load(3, 3, 1'b0, 32'h500);
        rd0 = rd_count;
        cfg_write(REG_CTRL, 32'd2);
        tick(8);
        check1("mid_busy", busy, 1'b1);
        check32("mid_left", 32'(exp_q.size()), 32'd0);
        cfg_write(REG_CTRL, 32'd2);
        queue_load(8, 8, 1'b0, 32'h600);
        wait_idle("restart", 100);
        check32("restart_reads", 32'(rd_count - rd0), 32'd11);
        check32("restart_left", 32'(exp_q.size()), 32'd0);
        check1("restart_ready", weights_ready, 1'b1);

        // Async reset mid-LOAD
        cfg_write(REG_KWORDS, 32'd32);
        queue_load(32, 32, 1'b1, 32'd0);
        rd0 = rd_count;
        cfg_write(REG_CTRL, 32'd2);
        wait_reads("arst", rd0 + 5);
        bus_rst_n = 1'b0;
        #1;
        check1("arst_busy", busy, 1'b0);
        check1("arst_rd_en", kfifo_rd_en, 1'b0);
        check1("arst_we", wmem_we, 1'b0);
        check32("arst_addr", 32'(wmem_addr), 32'd0);
        check32("arst_wdata", wmem_wdata, 32'd0);
        check1("arst_ready", weights_ready, 1'b0);
        check1("arst_err", load_error, 1'b0);
        check32("arst_geom", {img_width, img_height}, 32'd0);
        check32("arst_nch", 32'(num_ch), 32'd0);
        exp_q.delete();
        fifo_q.delete();
        tick(2);
        bus_rst_n = 1'b1;
        tick(3);
        check1("post_rst_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_weight_loader.md
Name: kernel_weight_loader

Overview:
- Sits directly downstream of the Xillybus core, on bus_clk.
- Consumes the config write stream (5-bit addressed, 32-bit data) into a small register file.
- Drains the kernel_32 write FIFO (standard, non-FWFT read side) into the convolution pipeline's weight RAM, counting words against a programmed length.
- Exports image geometry, weights_ready and a start pulse to the feature convolution pipeline.

Parameters:
- ADDR_W, 12, weight RAM address width; capacity 2**ADDR_W 32-bit words.
- MAX_CH, 64, largest legal NUM_CH value.

Ports:
- bus_clk  in  1  clock
- bus_rst_n  in  1  asynchronous active-low reset
- cfg_wren  in  1  config write strobe (user_w_config_wren)
- cfg_addr  in  5  config register address (user_config_addr)
- cfg_data  in  32  config write data
- cfg_full  out  1  tied 0; writes always accepted
- kernel_open  in  1  kernel stream open flag (user_w_write_kernel_32_open)
- kfifo_dout  in  32  kernel FIFO read data, valid the cycle after rd_en
- kfifo_empty  in  1  kernel FIFO empty
- kfifo_rd_en  out  1  kernel FIFO read enable
- wmem_we  out  1  weight RAM write enable
- wmem_addr  out  ADDR_W  weight RAM write address
- wmem_wdata  out  32  weight RAM write data
- img_width  out  16  register IMG_WIDTH
- img_height  out  16  register IMG_HEIGHT
- num_ch  out  8  register NUM_CH
- weights_ready  out  1  full kernel set stored
- load_error  out  1  sticky error flag
- busy  out  1  high in LOAD
- start  out  1  one-cycle start pulse to the pipeline

Behaviour:
- Reset: all outputs 0; all registers 0; FSM in IDLE.
- Register map, written when cfg_wren=1. Writes to other addresses are ignored.
  - addr 0, CTRL:
    - bit0 = START. Pulses start for 1 cycle (the cycle after the write) only if weights_ready=1; otherwise ignored.
    - bit1 = ARM. Clears load_error and weights_ready, then enters LOAD when KWORDS is legal.
  - addr 1, KWORDS: words[ADDR_W:0]. Ignored while busy.
  - addr 2, IMG_WIDTH: [15:0].
  - addr 3, IMG_HEIGHT: [15:0].
  - addr 4, NUM_CH: [7:0]. A value > MAX_CH sets load_error and the register keeps its old value.
- ARM legality: KWORDS=0 or KWORDS > 2**ADDR_W -> load_error=1 and the FSM stays IDLE.
- FSM states: IDLE, LOAD, DONE, ERR.
- IDLE: kfifo_rd_en=0. Words in the FIFO are left unconsumed (the FIFO backs up).
- LOAD:
  - rd_cnt and wr_cnt start at 0; busy=1.
  - kfifo_rd_en = !kfifo_empty && rd_cnt<KWORDS; rd_cnt increments on each rd_en.
  - Read data is registered 1 cycle later: wmem_we=1, wmem_addr=wr_cnt, wmem_wdata=kfifo_dout; wr_cnt then increments.
  - Write latency from rd_en: 1 cycle. Throughput: 1 word/cycle.
  - When the write with wr_cnt=KWORDS-1 completes -> DONE. weights_ready=1 from the next cycle.
  - kernel_open falling while rd_cnt<KWORDS -> ERR.
    - The in-flight word (rd_en asserted the previous cycle) is still written.
    - No further reads.
    - load_error=1, weights_ready stays 0.
- DONE: weights_ready=1, rd_en=0. START is accepted here.
- ERR: rd_en=0, load_error=1.
- Leaving DONE or ERR: an ARM write restarts LOAD (counters reset; previous RAM contents are overwritten as the load proceeds).
- ARM write during LOAD: restart. Counters reset, any in-flight data word is discarded (its wmem_we is suppressed), load_error is cleared.
- Simultaneous events:
  - START and ARM in the same write: ARM wins and no start pulse is issued.
  - Config write in the same cycle as the final RAM write: both take effect.
- Count ceiling: wr_cnt never exceeds KWORDS. wmem_addr never wraps because KWORDS ≤ 2**ADDR_W.
- Mid-operation reset: asynchronous return to the reset state. RAM contents are not cleared.

Decomposition:
- Package kwl_pkg:
  - register address constants (CTRL=0, KWORDS=1, IMG_W=2, IMG_H=3, NUM_CH=4);
  - CTRL bit indices;
  - FSM state enum.
- One sub-module, kwl_cfg_regs: register file, START/ARM decode and NUM_CH legality check.
- The FSM, counters and RAM write path stay in the top level.

Test Plan:
- Register readback: write IMG_WIDTH=640, IMG_HEIGHT=480, NUM_CH=3 -> img_width=640, img_height=480, num_ch=3 the cycle after each write; cfg_full stays 0.
- Basic load: KWORDS=9, ARM; FIFO supplies 9 words 0x100..0x108 back-to-back -> 9 consecutive wmem_we cycles at addr 0..8 with matching data, each 1 cycle after its rd_en; weights_ready=1 after the last write; exactly 9 rd_en pulses.
- Empty gaps: same load with kfifo_empty toggling every other cycle -> no rd_en while empty, RAM contents identical, a 10th FIFO word is not read.
- Early close: KWORDS=16, drop kernel_open after 5 reads -> exactly 5 RAM writes; load_error=1, weights_ready=0, busy=0; a following ARM clears load_error.
- Illegal values: ARM with KWORDS=0 -> load_error=1 and FSM stays IDLE; KWORDS=4097 with ADDR_W=12 -> load_error=1; NUM_CH=65 -> load_error=1 and num_ch unchanged.
- Start and reset: START before load -> no pulse; after DONE, START -> exactly one start cycle; START+ARM together -> no pulse; async reset mid-LOAD -> all outputs 0 immediately.
